// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_pkg
// Description : Shared definitions for the multi-port integer register file.
//               Holds the default geometry, the hardwired-zero register index
//               and the init-sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

  localparam int DEF_XLEN    = 64;
  localparam int DEF_NREGS   = 32;
  localparam int DEF_SP_IDX  = 2;
  localparam int DEF_SP_INIT = 128;

  // x0 reads as zero and ignores writes
  localparam int ZERO_REG    = 0;

  typedef enum logic [0:0] {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

endpackage
`default_nettype wire

// File: rtl/rf_init_seq.sv
`default_nettype none
// ============================================================================
// Module      : rf_init_seq
// Description : Post-reset init sequencer. Walks every register index once,
//               one per cycle, then parks in RUN until the next reset.
// Revision    : 1.0 - initial release
// Ports       :
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active-high
//   init_we    out  storage write strobe for the current init index
//   init_addr  out  register index being initialised
//   init_done  out  high while in RUN
// ============================================================================
module rf_init_seq
  import rf_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          init_we,
  output logic [AW-1:0] init_addr,
  output logic          init_done
);

  rf_state_e     r_state;
  rf_state_e     w_state_nxt;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RF_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    init_we     = 1'b0;
    init_addr   = r_cnt;
    init_done   = 1'b0;
    case (r_state)
      RF_INIT: begin
        // a reset cycle must not disturb storage
        init_we   = ~rst;
        w_cnt_nxt = r_cnt + AW'(1);
        if (r_cnt == AW'(NREGS - 1)) begin
          w_state_nxt = RF_RUN;
        end
      end
      RF_RUN: begin
        init_done = 1'b1;
      end
      default: begin
        w_state_nxt = RF_INIT;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rf_multiport.sv
`default_nettype none
// ============================================================================
// Module      : rf_multiport
// Description : Parametrised integer register file with NRD combinational
//               read ports, NWR write ports (higher index wins), same-cycle
//               write-to-read bypass, x0 hardwired to zero and a post-reset
//               init sequence that clears storage and loads the stack pointer.
//               Optional scoreboard enabled by macro RF_SCOREBOARD_EN.
// Revision    : 1.0 - initial release
// Ports       :
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active-high
//   init_done  out  high once the init sequence completes
//   rd_addr    in   NRD*AW read addresses, port p at [p*AW +: AW]
//   rd_data    out  NRD*XLEN read data, combinational
//   wr_en      in   NWR write enables
//   wr_addr    in   NWR*AW write addresses
//   wr_data    in   NWR*XLEN write data
//   sb_set     in   mark register sb_addr busy
//   sb_addr    in   scoreboard set address
//   rd_busy    out  NRD source-pending flags (0 when RF_SCOREBOARD_EN unset)
// ============================================================================
module rf_multiport
  import rf_pkg::*;
#(
  parameter  int XLEN    = DEF_XLEN,
  parameter  int NREGS   = DEF_NREGS,
  parameter  int NRD     = 2,
  parameter  int NWR     = 2,
  parameter  int SP_IDX  = DEF_SP_IDX,
  parameter  int SP_INIT = DEF_SP_INIT,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                init_done,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_addr,
  output logic [NRD-1:0]      rd_busy
);

  // --------------------------------------------------------------------------
  // Init sequencer
  // --------------------------------------------------------------------------
  logic          w_init_we;
  logic [AW-1:0] w_init_addr;
  logic          w_run;
  logic [XLEN-1:0] w_init_wdata;

  rf_init_seq #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_init_seq (
    .clk       (clk),
    .rst       (rst),
    .init_we   (w_init_we),
    .init_addr (w_init_addr),
    .init_done (w_run)
  );

  assign init_done    = w_run;
  assign w_init_wdata = (w_init_addr == AW'(SP_IDX)) ? XLEN'(SP_INIT) : '0;

  // --------------------------------------------------------------------------
  // Write port decode: a port is effective only in RUN, outside reset and
  // when it does not target x0
  // --------------------------------------------------------------------------
  logic            w_wr_vld  [NWR];
  logic [AW-1:0]   w_wr_addr [NWR];
  logic [XLEN-1:0] w_wr_data [NWR];

  for (genvar w = 0; w < NWR; w++) begin : g_wr
    assign w_wr_addr[w] = wr_addr[w*AW +: AW];
    assign w_wr_data[w] = wr_data[w*XLEN +: XLEN];
    assign w_wr_vld[w]  = w_run & ~rst & wr_en[w] & (w_wr_addr[w] != AW'(ZERO_REG));
  end

  // --------------------------------------------------------------------------
  // Storage. Ports are visited in ascending order so the last (highest)
  // matching port's assignment is the one that lands.
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] r_regs [NREGS];

  always_ff @(posedge clk) begin
    if (w_init_we) begin
      r_regs[w_init_addr] <= w_init_wdata;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (w_wr_vld[w]) begin
          r_regs[w_wr_addr[w]] <= w_wr_data[w];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
`ifdef RF_SCOREBOARD_EN
  logic [NREGS-1:0] r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else if (w_run) begin
      for (int w = 0; w < NWR; w++) begin
        if (w_wr_vld[w]) begin
          r_busy[w_wr_addr[w]] <= 1'b0;
        end
      end
      // issued after the clears so a new producer overrides a retiring one
      if (sb_set && (sb_addr != AW'(ZERO_REG))) begin
        r_busy[sb_addr] <= 1'b1;
      end
    end
  end
`else
  logic w_unused_sb;
  assign w_unused_sb = ^{sb_set, sb_addr};
`endif

  // --------------------------------------------------------------------------
  // Read ports with bypass from the highest matching write port
  // --------------------------------------------------------------------------
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   w_ra;
    logic            w_hit;
    logic [XLEN-1:0] w_byp;

    assign w_ra = rd_addr[p*AW +: AW];

    always_comb begin
      w_hit = 1'b0;
      w_byp = '0;
      for (int w = 0; w < NWR; w++) begin
        if (w_wr_vld[w] && (w_wr_addr[w] == w_ra)) begin
          w_hit = 1'b1;
          w_byp = w_wr_data[w];
        end
      end
    end

    assign rd_data[p*XLEN +: XLEN] = (!w_run || (w_ra == AW'(ZERO_REG))) ? '0 :
                                     w_hit ? w_byp : r_regs[w_ra];

`ifdef RF_SCOREBOARD_EN
    assign rd_busy[p] = w_run & r_busy[w_ra] & ~w_hit;
`else
    assign rd_busy[p] = 1'b0;
`endif
  end

endmodule
`default_nettype wire
